// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory port arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 28;
  localparam int DEF_LINE_W = 128;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BUSY_I = 3'd1,
    S_BUSY_D = 3'd2,
    S_RESP_I = 3'd3,
    S_RESP_D = 3'd4
  } state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Grant picker for the memory port arbiter.
// MEM_PORT_ARB_RR_EN defined  : round-robin between I and D on conflict.
// MEM_PORT_ARB_RR_EN undefined: fixed priority, D always beats I.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_sel
);

  assign grant_valid = req_i | req_d;

`ifdef MEM_PORT_ARB_RR_EN
  // on a conflict the side that was not served last wins
  always_comb begin
    grant_sel = GNT_I;
    if (req_i && req_d) begin
      grant_sel = (last_grant == GNT_I) ? GNT_D : GNT_I;
    end else if (req_d) begin
      grant_sel = GNT_D;
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = last_grant;
  assign grant_sel     = req_d ? GNT_D : GNT_I;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between the I-cache fill path and the
// D-cache fill/writeback path. One transaction outstanding at a time.
// Arbitration policy is selected by MEM_PORT_ARB_RR_EN (see arb_pick).
//
// state    | meaning
// ---------+-----------------------------------------------------
// S_IDLE   | bus free, requests sampled and arbitrated each cycle
// S_BUSY_I | I-cache read held on the bus until mem_ready
// S_BUSY_D | D-cache read or write held on the bus until mem_ready
// S_RESP_I | one-cycle i_mem_ready pulse
// S_RESP_D | one-cycle d_mem_ready pulse
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_t r_state;
  state_t w_state_nxt;

  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LINE_W-1:0] r_mem_wdata;
  logic [LINE_W-1:0] r_i_rdata;
  logic [LINE_W-1:0] r_d_rdata;

  logic w_req_d;
  logic w_gnt_valid;
  logic w_gnt_sel;
  logic w_last_grant;
  logic w_grant;
  logic w_busy_done;

  assign w_req_d     = d_mem_read | d_mem_write;
  assign w_grant     = (r_state == S_IDLE) && w_gnt_valid;
  assign w_busy_done = ((r_state == S_BUSY_I) || (r_state == S_BUSY_D)) && mem_ready;

  arb_pick u_arb_pick (
    .req_i       (i_mem_read),
    .req_d       (w_req_d),
    .last_grant  (w_last_grant),
    .grant_valid (w_gnt_valid),
    .grant_sel   (w_gnt_sel)
  );

`ifdef MEM_PORT_ARB_RR_EN
  logic r_last_grant;

  // remember which side was served most recently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= GNT_I;
    end else if (w_grant) begin
      r_last_grant <= w_gnt_sel;
    end
  end

  assign w_last_grant = r_last_grant;
`else
  assign w_last_grant = GNT_I;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state decode; mem_ready outside BUSY is ignored
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_gnt_valid) begin
          w_state_nxt = (w_gnt_sel == GNT_D) ? S_BUSY_D : S_BUSY_I;
        end
      end
      S_BUSY_I: if (mem_ready) w_state_nxt = S_RESP_I;
      S_BUSY_D: if (mem_ready) w_state_nxt = S_RESP_D;
      S_RESP_I: w_state_nxt = S_IDLE;
      S_RESP_D: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // capture the granted request, hold it on the bus, latch returned data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else if (w_grant) begin
      if (w_gnt_sel == GNT_D) begin
        // simultaneous read+write from D is illegal; the write wins
        r_mem_addr  <= d_mem_addr;
        r_mem_wdata <= d_mem_wdata;
        r_mem_write <= d_mem_write;
        r_mem_read  <= ~d_mem_write;
      end else begin
        r_mem_addr  <= i_mem_addr;
        r_mem_write <= 1'b0;
        r_mem_read  <= 1'b1;
      end
    end else if (w_busy_done) begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      if (r_state == S_BUSY_I) begin
        r_i_rdata <= mem_rdata;
      end else begin
        r_d_rdata <= mem_rdata;
      end
    end
  end

  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign i_mem_rdata = r_i_rdata;
  assign d_mem_rdata = r_d_rdata;
  assign i_mem_ready = (r_state == S_RESP_I);
  assign d_mem_ready = (r_state == S_RESP_D);

endmodule
